// File: rtl/mp_add_sequencer.sv
// -----------------------------------------------------------------------------
// mp_add_sequencer
//   Multi-precision add/subtract sequencer. Operand word pairs arrive least
//   significant word first over a valid/ready stream. Each word goes through
//   one 18-bit prefix adder. The carry-out of each word is chained into the
//   carry-in of the next word. Each sum word is registered and streamed out
//   over a single-entry valid/ready pipeline stage.
//
//   Subtraction is computed as A + ~B + 1. The +1 enters as the carry-in of
//   the LS word, so on the MS word out_cout = 1 means "no borrow".
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           operand beat handshake
//   in_a, in_b                  operand words
//   in_first, in_last, in_sub   framing and mode (in_sub is sampled on the first beat only)
//   out_valid/out_ready         result beat handshake
//   out_sum, out_idx            result word and its word index
//   out_last, out_cout          MS-word marker and the final carry
//   err                         sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------

// Kogge-Stone prefix adder with a carry-in.
module mp_prefix_add #(
  parameter int W = 18
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  logic [W-1:0] p, gg, pp;

  // NOTE: every combinational output gets a value on every path before any
  // conditional update. This keeps synthesis from inferring a latch.
  always_comb begin
    p      = a_i ^ b_i;
    gg     = a_i & b_i;
    // Fold the carry-in into bit 0 so the prefix tree sees it as a generate.
    gg[0]  = gg[0] | (p[0] & cin_i);
    pp     = p;
    for (int d = 1; d < W; d = d * 2) begin
      // Walk downward so that index i-d still holds the previous level's value.
      for (int i = W - 1; i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    sum_o  = p ^ {gg[W-2:0], cin_i};
    cout_o = gg[W-1];
  end
endmodule

module mp_add_sequencer #(
  parameter  int WIDTH     = 18,   // fixed to the adder width
  parameter  int MAX_WORDS = 16,
  localparam int IDX_W     = $clog2(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_cout,
  output logic             err
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e             state_q, state_d;
  logic               carry_q, carry_d;
  logic               sub_q, sub_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_sum_q, out_sum_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic               out_last_q, out_last_d;
  logic               out_cout_q, out_cout_d;
  logic               err_q, err_d;

  logic               accept, start, mode, cin;
  logic [WIDTH-1:0]   b_op, sum;
  logic               cout;

  // The output register is the only storage, so a new beat can enter
  // whenever that register is empty or is being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // In IDLE every beat starts a new operand, even if in_first is low.
  // in_first in BUSY abandons the current operand.
  assign start    = (state_q == IDLE) || in_first;
  assign mode     = start ? in_sub : sub_q;
  assign b_op     = mode ? ~in_b : in_b;
  assign cin      = start ? mode : carry_q;

  mp_prefix_add #(.W(WIDTH)) u_add (
    .a_i   (in_a),
    .b_i   (b_op),
    .cin_i (cin),
    .sum_o (sum),
    .cout_o(cout)
  );

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    err_d       = err_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum;
      carry_d     = cout;
      out_last_d  = in_last;
      out_cout_d  = in_last ? cout : 1'b0;
      if (start) begin
        sub_d     = in_sub;
        out_idx_d = '0;
        // A missing in_first in IDLE and an early in_first in BUSY are both errors.
        if ((state_q == IDLE) != in_first) err_d = 1'b1;
        if (in_last) begin
          state_d = IDLE;
        end else begin
          cnt_d   = IDX_W'(1);
          state_d = BUSY;
        end
      end else begin
        out_idx_d = cnt_q;
        if (in_last) begin
          state_d = IDLE;
        end else if (cnt_q == IDX_W'(MAX_WORDS - 1)) begin
          // The operand is too long. cnt saturates and carry chaining continues.
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop
  // samples its _d value from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign err       = err_q;
endmodule
